mux_4x1: RTL and testbench
==========================

Name: mux_4x1

Overview:
- Registered 4-to-1 multiplexer.
- Routes one of four data inputs (d0..d3) to output y, chosen by two select bits (s1 = MSB, s0 = LSB).
- Output is registered on the single clock, giving a clean, glitch-free select path for downstream datapath logic.
- Used as a leaf selection element wherever a timed 4-way source choice is needed.

Parameters:
- WIDTH, 1, bit width of each data input d0..d3 and of output y (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- s0  input  1  select LSB.
- s1  input  1  select MSB.
- d0  input  WIDTH  data input, chosen when {s1,s0} = 2'b00.
- d1  input  WIDTH  data input, chosen when {s1,s0} = 2'b01.
- d2  input  WIDTH  data input, chosen when {s1,s0} = 2'b10.
- d3  input  WIDTH  data input, chosen when {s1,s0} = 2'b11.
- y  output  WIDTH  registered selected data.
- sel_q  output  2  registered copy of {s1,s0} that produced the current y.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: rst_n low immediately (no clock needed) forces y = 0 and sel_q = 2'b00. This holds while rst_n is low.
- Release: the first rising clk edge after rst_n deasserts samples the inputs normally. No extra settling cycles.
- Selection: sel = {s1,s0}. 00 -> d0, 01 -> d1, 10 -> d2, 11 -> d3.
- Latency: exactly 1 cycle. Inputs present before rising edge N appear on y and sel_q after edge N.
- No enable and no hold state: y is updated every clock edge.
- A select change and a data change in the same cycle are both captured at the same edge. The data that is selected is always the value present at that edge.
- Reset asserted mid-operation: y and sel_q clear asynchronously. Any in-flight value is discarded.
- Unknown selects (X/Z on s0 or s1) after reset are illegal stimulus. The design is not required to produce a defined value for them. An implementation must not infer latches.
- All WIDTH bits are routed identically. There is no arithmetic and no width extension.

Optional Feature:
- Macro: MUX_4X1_PARITY_EN.
- When defined: adds output y_par (1 bit), registered alongside y. y_par is the even parity (XOR reduction) of the selected data. It has the same 1-cycle latency and resets to 0.
- When undefined: the y_par port and its logic are absent. Everything else is unchanged.

Decomposition:
- Package mux_4x1_pkg holds:
  - typedef sel_t (2-bit logic);
  - constants SEL_D0 = 2'b00, SEL_D1 = 2'b01, SEL_D2 = 2'b10, SEL_D3 = 2'b11.
- One natural sub-module: mux_4x1_onehot_dec. It decodes sel_t into a 4-bit one-hot vector, which drives an AND-OR data selection in the top level.
- Registers stay in mux_4x1.

Test Plan:
- Reset: with d0..d3 = 1,0,1,1, assert rst_n = 0 mid-cycle -> y = 0 and sel_q = 00 immediately, before any clk edge.
- Full select sweep (WIDTH = 1): d0 = 1, d1 = 0, d2 = 1, d3 = 1; apply {s1,s0} = 00, 01, 10, 11 on successive cycles -> y = 1, 0, 1, 1, each one cycle after its select, with sel_q tracking 00, 01, 10, 11.
- Latency check (WIDTH = 8): d2 = 8'hA5, {s1,s0} = 10 applied before edge N -> y = 8'hA5 after edge N, not before.
- Same-cycle change: select held at 01; in one cycle change d1 from 8'h3C to 8'hC3 and the select to 11 with d3 = 8'h7E -> y = 8'h7E at the next edge.
- Mid-run reset: sweep running with y = 8'hFF; pulse rst_n low for half a cycle -> y = 8'h00 at once; after release the next edge resumes correct selection.
- With MUX_4X1_PARITY_EN defined (WIDTH = 8): select d0 = 8'b0000_0111 -> y_par = 1; select d1 = 8'b0000_0011 -> y_par = 0; each appears with the same 1-cycle latency as y.

Source files
------------

// File: rtl/mux_4x1_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mux_4x1_pkg                                                    |
// | Desc    : Shared select type and select-code constants for mux_4x1.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mux_4x1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;
    localparam sel_t SEL_D3 = 2'b11;

endpackage : mux_4x1_pkg
`default_nettype wire

// File: rtl/mux_4x1_onehot_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mux_4x1_onehot_dec                                             |
// | Desc    : Decodes a 2-bit select code into a 4-bit one-hot vector.       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mux_4x1_onehot_dec
    import mux_4x1_pkg::*;
(
    input  sel_t       sel,
    output logic [3:0] onehot
);

    // Unknown select codes collapse to all-zeros so no latch is inferred.
    always_comb begin
        onehot = 4'b0000;
        unique case (sel)
            SEL_D0:  onehot = 4'b0001;
            SEL_D1:  onehot = 4'b0010;
            SEL_D2:  onehot = 4'b0100;
            SEL_D3:  onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    end

endmodule : mux_4x1_onehot_dec
`default_nettype wire

// File: rtl/mux_4x1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mux_4x1                                                        |
// | Desc    : Registered 4-to-1 mux; optional y_par parity output is built   |
// |           when MUX_4X1_PARITY_EN is defined.                             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       sel_q
`ifdef MUX_4X1_PARITY_EN
    ,
    output logic             y_par
`endif
);

    sel_t             sel_d;
    logic [3:0]       onehot;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    assign sel_d = {s1, s0};

    mux_4x1_onehot_dec u_dec (
        .sel    (sel_d),
        .onehot (onehot)
    );

    // AND-OR selection keeps every data bit on an identical, balanced path.
    always_comb begin
        y_d = ({WIDTH{onehot[0]}} & d0)
            | ({WIDTH{onehot[1]}} & d1)
            | ({WIDTH{onehot[2]}} & d2)
            | ({WIDTH{onehot[3]}} & d3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= SEL_D0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
        end
    end

    assign y = y_q;

`ifdef MUX_4X1_PARITY_EN
    logic y_par_d;
    logic y_par_q;

    assign y_par_d = ^y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par_q <= 1'b0;
        end else begin
            y_par_q <= y_par_d;
        end
    end

    assign y_par = y_par_q;
`endif

endmodule : mux_4x1
`default_nettype wire

// File: tb/tb_mux_4x1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mux_4x1                                                     |
// | Desc    : Self-checking bench for mux_4x1 (WIDTH = 8).                   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mux_4x1;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   sel;
    logic [W-1:0] din [4];
    logic [W-1:0] y;
    logic [1:0]   sel_q;
`ifdef MUX_4X1_PARITY_EN
    logic         y_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_y;
    logic [1:0]   exp_sel;
    logic         exp_par;

    mux_4x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s0    (sel[0]),
        .s1    (sel[1]),
        .d0    (din[0]),
        .d1    (din[1]),
        .d2    (din[2]),
        .d3    (din[3]),
        .y     (y),
        .sel_q (sel_q)
`ifdef MUX_4X1_PARITY_EN
        ,
        .y_par (y_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whichever input the select names, as seen just before the edge.
    task automatic predict();
        exp_y   = din[sel];
        exp_sel = sel;
        exp_par = ($countones(din[sel]) % 2) == 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_y"}, 64'(y), 64'(exp_y));
        check({tag, "_sel"}, 64'(sel_q), 64'(exp_sel));
`ifdef MUX_4X1_PARITY_EN
        check({tag, "_par"}, 64'(y_par), 64'(exp_par));
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        sel    = 2'b00;
        din[0] = 8'h01;
        din[1] = 8'h00;
        din[2] = 8'h01;
        din[3] = 8'h01;
        #2;
        check("reset_y", 64'(y), 64'h0);
        check("reset_sel", 64'(sel_q), 64'h0);
        rst_n = 1'b1;

        // Select sweep 00..11, one cycle latency each.
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            predict();
            tick();
            check_outputs("sweep");
        end

        // Asynchronous reset mid-cycle, no clock edge needed.
        #1 rst_n = 1'b0;
        #1;
        check("areset_y", 64'(y), 64'h0);
        check("areset_sel", 64'(sel_q), 64'h0);
        #4 rst_n = 1'b1;

        // Latency: new select/data must not appear before the edge.
        din[0] = 8'h11;
        sel    = 2'b00;
        predict();
        tick();
        check_outputs("lat_pre");
        din[2] = 8'hA5;
        sel    = 2'b10;
        #1;
        check("lat_early_y", 64'(y), 64'h11);
        predict();
        tick();
        check_outputs("lat_post");

        // Select and data change in the same cycle.
        din[1] = 8'h3C;
        sel    = 2'b01;
        predict();
        tick();
        check("same_hold_y", 64'(y), 64'h3C);
        din[1] = 8'hC3;
        din[3] = 8'h7E;
        sel    = 2'b11;
        predict();
        tick();
        check("same_chg_y", 64'(y), 64'h7E);
        check("same_chg_sel", 64'(sel_q), 64'h3);

        // Mid-run reset with y = FF, then resume.
        din[0] = 8'hFF;
        sel    = 2'b00;
        predict();
        tick();
        check("pre_rst_y", 64'(y), 64'hFF);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_y", 64'(y), 64'h00);
        check("midrst_sel", 64'(sel_q), 64'h0);
        #3 rst_n = 1'b1;
        din[2] = 8'h5A;
        sel    = 2'b10;
        predict();
        tick();
        check_outputs("resume");

`ifdef MUX_4X1_PARITY_EN
        din[0] = 8'b0000_0111;
        din[1] = 8'b0000_0011;
        sel    = 2'b00;
        tick();
        check("par_d0", 64'(y_par), 64'h1);
        sel = 2'b01;
        #1;
        check("par_d0_hold", 64'(y_par), 64'h1);
        tick();
        check("par_d1", 64'(y_par), 64'h0);
`endif

        // Randomized select and data against the reference.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) din[k] = W'($urandom);
            sel = 2'($urandom_range(0, 3));
            predict();
            tick();
            check_outputs("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_4x1
`default_nettype wire
